// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider.
// Takes one dividend/divisor pair per operation and returns {remainder, quotient}
// on a single-cycle result strobe. It produces one quotient bit per clock.
// SIGNED selects two's-complement operands (truncating division) or unsigned operands.
`timescale 1ns/1ps

module div_iter #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  cancel,
  output logic                  m_axis_dout_tvalid,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [DATA_W-1:0] ALL_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Two's-complement negation.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ALL_ZERO - x;
  endfunction

  // Unsigned magnitude of an operand. The most negative value maps to 2^(W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    if (SIGNED && x[DATA_W-1]) begin
      return negate(x);
    end else begin
      return x;
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                accept_s;
  logic [DATA_W-1:0]   dividend_r;
  logic [DATA_W-1:0]   divisor_r;
  logic [DATA_W-1:0]   bmag_r;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   quo_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                qneg_r;
  logic                rneg_r;
  logic [DATA_W:0]     rem_shift_s;
  logic [DATA_W:0]     trial_s;
  logic [DATA_W-1:0]   rem_nxt_s;
  logic [DATA_W-1:0]   quo_nxt_s;
  logic [2*DATA_W-1:0] result_s;
  logic [2*DATA_W-1:0] tdata_r;
  logic                tvalid_r;
  logic                ready_s;

  // Both operand channels share one ready: IDLE only, and a flush always holds it low.
  assign ready_s                = (state_r == ST_IDLE) && !cancel;
  assign s_axis_divisor_tready  = ready_s;
  assign s_axis_dividend_tready = ready_s;
  assign m_axis_dout_tvalid     = tvalid_r;
  assign m_axis_dout_tdata      = tdata_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A flush returns to IDLE from every state; DONE always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cancel && s_axis_divisor_tvalid && s_axis_dividend_tvalid) begin
          state_nxt_s = ST_PREP;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_ITER: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_ITER;
        end
      end
      ST_FIX: begin
        if (cancel) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // One restoring step. The partial remainder is W+1 bits wide once it is shifted.
  // The divisor magnitude is at most 2^W-1, so a W+1-bit subtraction shows the sign in its MSB.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[DATA_W-1]};
    trial_s     = rem_shift_s - {1'b0, bmag_r};
    if (trial_s[DATA_W]) begin
      rem_nxt_s = rem_shift_s[DATA_W-1:0];
      quo_nxt_s = {quo_r[DATA_W-2:0], 1'b0};
    end else begin
      rem_nxt_s = trial_s[DATA_W-1:0];
      quo_nxt_s = {quo_r[DATA_W-2:0], 1'b1};
    end
  end

  // Final result: divide-by-zero bypasses the sign fixup; signed builds restore the signs.
  // MIN/-1 needs no special case: |MIN|/1 = 2^(W-1) = MIN, and both sign flags cancel.
  always_comb begin
    result_s = {rem_r, quo_r};
    if (divisor_r == ALL_ZERO) begin
      result_s = {dividend_r, ALL_ONES};
    end else if (SIGNED) begin
      result_s = {(rneg_r ? negate(rem_r) : rem_r),
                  (qneg_r ? negate(quo_r) : quo_r)};
    end else begin
      result_s = {rem_r, quo_r};
    end
  end

  // Datapath registers: capture operands, prepare magnitudes, iterate, and register the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_r <= ALL_ZERO;
      divisor_r  <= ALL_ZERO;
      bmag_r     <= ALL_ZERO;
      rem_r      <= ALL_ZERO;
      quo_r      <= ALL_ZERO;
      cnt_r      <= CNT_ZERO;
      qneg_r     <= 1'b0;
      rneg_r     <= 1'b0;
      tdata_r    <= {(2*DATA_W){1'b0}};
      tvalid_r   <= 1'b0;
    end else begin
      tvalid_r <= (state_r == ST_FIX) && !cancel;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            dividend_r <= s_axis_dividend_tdata;
            divisor_r  <= s_axis_divisor_tdata;
          end
        end
        ST_PREP: begin
          rem_r  <= ALL_ZERO;
          quo_r  <= magnitude(dividend_r);
          bmag_r <= magnitude(divisor_r);
          qneg_r <= dividend_r[DATA_W-1] ^ divisor_r[DATA_W-1];
          rneg_r <= dividend_r[DATA_W-1];
          cnt_r  <= CNT_ZERO;
        end
        ST_ITER: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          if (!cancel) begin
            tdata_r <= result_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomized bench for div_iter.
// Signed and unsigned instances run side by side on the same operands.
`timescale 1ns/1ps

module tb_div_iter;

  localparam int LAT = 35;

  logic        clk;
  logic        reset;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        dvd_valid;
  logic        dvs_valid;

  logic        rdy_dvs_s, rdy_dvd_s, tv_s;
  logic [63:0] td_s;
  logic        rdy_dvs_u, rdy_dvd_u, tv_u;
  logic [63:0] td_u;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_s;
    logic [63:0] exp_u;
  } vec_t;

  vec_t vecs[13];

  div_iter #(.DATA_W(32), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_dvs_s),
    .s_axis_divisor_tdata(divisor),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_dvd_s),
    .s_axis_dividend_tdata(dividend),
    .cancel(cancel),
    .m_axis_dout_tvalid(tv_s), .m_axis_dout_tdata(td_s)
  );

  div_iter #(.DATA_W(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_dvs_u),
    .s_axis_divisor_tdata(divisor),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_dvd_u),
    .s_axis_dividend_tdata(dividend),
    .cancel(cancel),
    .m_axis_dout_tvalid(tv_u), .m_axis_dout_tdata(td_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  function automatic logic all_ready();
    return rdy_dvs_s & rdy_dvd_s & rdy_dvs_u & rdy_dvd_u;
  endfunction

  function automatic logic any_ready();
    return rdy_dvs_s | rdy_dvd_s | rdy_dvs_u | rdy_dvd_u;
  endfunction

  // One handshake, then wait (bounded) for each instance's result strobe.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] rs, output logic [63:0] ru,
                        output int lat_s, output int lat_u);
    lat_s = -1;
    lat_u = -1;
    rs = 64'd0;
    ru = 64'd0;
    @(negedge clk);
    dividend = a;
    divisor = b;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (tv_s && lat_s < 0) begin lat_s = n; rs = td_s; end
      if (tv_u && lat_u < 0) begin lat_u = n; ru = td_u; end
      if (lat_s >= 0 && lat_u >= 0) break;
    end
  endtask

  task automatic watch_idle(input int ncyc, output int seen);
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (tv_s || tv_u) seen++;
    end
  endtask

  initial begin
    logic [63:0] rs, ru;
    int lat_s, lat_u, seen, first, second;
    logic [63:0] second_data;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    cancel = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;

    vecs[0]  = '{32'd100,       32'd7,         64'h00000002_0000000E, 64'h00000002_0000000E};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC};
    vecs[2]  = '{32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 64'h00000007_00000000};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 64'h80000000_00000000};
    vecs[4]  = '{32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 64'h00000000_FFFFFFFF};
    vecs[5]  = '{32'd5,         32'd0,         64'h00000005_FFFFFFFF, 64'h00000005_FFFFFFFF};
    vecs[6]  = '{32'hFFFFFFF9,  32'd0,         64'hFFFFFFF9_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF};
    vecs[7]  = '{32'd9,         32'd3,         64'h00000000_00000003, 64'h00000000_00000003};
    vecs[8]  = '{32'd100,       32'hFFFFFFF9,  64'h00000002_FFFFFFF2, 64'h00000064_00000000};
    vecs[9]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 64'hFFFFFF9C_00000000};
    vecs[10] = '{32'h80000000,  32'd1,         64'h00000000_80000000, 64'h00000000_80000000};
    vecs[11] = '{32'd0,         32'd5,         64'h00000000_00000000, 64'h00000000_00000000};
    vecs[12] = '{32'h80000000,  32'h80000000,  64'h00000000_00000001, 64'h00000000_00000001};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_tvalid", {62'd0, tv_s, tv_u}, 64'd0);
    check("reset_tdata_s", td_s, 64'd0);
    check("reset_tdata_u", td_u, 64'd0);
    check("reset_tready", {63'd0, all_ready()}, 64'd1);

    // Table-driven vectors: data, exact latency, one-cycle strobe, held tdata.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, rs, ru, lat_s, lat_u);
      check($sformatf("vec%0d_lat_s", i), 64'(lat_s), 64'(LAT));
      check($sformatf("vec%0d_lat_u", i), 64'(lat_u), 64'(LAT));
      check($sformatf("vec%0d_data_s", i), rs, vecs[i].exp_s);
      check($sformatf("vec%0d_data_u", i), ru, vecs[i].exp_u);
      @(negedge clk);
      check($sformatf("vec%0d_strobe_once", i), {62'd0, tv_s, tv_u}, 64'd0);
      check($sformatf("vec%0d_hold_s", i), td_s, vecs[i].exp_s);
      check($sformatf("vec%0d_ready_after", i), {63'd0, all_ready()}, 64'd1);
    end

    // Cancel mid-iteration: no result, ready again in the next cycle.
    @(negedge clk);
    dividend = 32'd1000;
    divisor = 32'd3;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel_busy_ready", {63'd0, any_ready()}, 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_ready_next", {63'd0, all_ready()}, 64'd1);
    watch_idle(50, seen);
    check("cancel_no_tvalid", 64'(seen), 64'd0);
    run_op(32'd9, 32'd3, rs, ru, lat_s, lat_u);
    check("after_cancel_lat", 64'(lat_s), 64'(LAT));
    check("after_cancel_data_s", rs, 64'h00000000_00000003);
    check("after_cancel_data_u", ru, 64'h00000000_00000003);

    // Cancel held in IDLE with both valids: ready stays low, nothing accepted.
    @(negedge clk);
    dividend = 32'd5;
    divisor = 32'd1;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    cancel = 1'b1;
    seen = 0;
    repeat (3) begin
      #1;
      if (any_ready()) seen++;
      @(negedge clk);
    end
    check("cancel_idle_ready_low", 64'(seen), 64'd0);
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    cancel = 1'b0;
    watch_idle(40, seen);
    check("cancel_idle_no_accept", 64'(seen), 64'd0);

    // Lone dividend valid for 5 cycles: ready stays high, nothing starts.
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      dividend = 32'd77;
      dvd_valid = 1'b1;
      #1;
      if (!all_ready()) seen++;
    end
    check("lone_valid_ready", 64'(seen), 64'd0);
    @(negedge clk);
    dvd_valid = 1'b0;
    watch_idle(40, seen);
    check("lone_valid_no_accept", 64'(seen), 64'd0);
    run_op(32'd77, 32'd7, rs, ru, lat_s, lat_u);
    check("after_lone_data_s", rs, 64'h00000000_0000000B);
    check("after_lone_lat", 64'(lat_u), 64'(LAT));

    // Back-to-back: valids held high, second accept in cycle 36, its result in cycle 71.
    first = -1;
    second = -1;
    second_data = 64'd0;
    seen = 0;
    @(negedge clk);
    dividend = 32'd9;
    divisor = 32'd3;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (tv_s) begin
        if (first < 0) begin
          first = n;
        end else if (second < 0) begin
          second = n;
          second_data = td_s;
        end
      end
      if (n == 35) begin
        dividend = 32'd100;
        divisor = 32'd7;
      end
      if (n == 36) begin
        #1;
        if (!all_ready()) seen++;
      end
      if (n == 37) begin
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
      end
      if (second >= 0) break;
    end
    check("b2b_first_cycle", 64'(first), 64'd35);
    check("b2b_ready_36", 64'(seen), 64'd0);
    check("b2b_second_cycle", 64'(second), 64'd71);
    check("b2b_second_data", second_data, 64'h00000002_0000000E);

    // Reset mid-operation: no result and tdata cleared.
    @(negedge clk);
    dividend = 32'd1000;
    divisor = 32'd3;
    dvd_valid = 1'b1;
    dvs_valid = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_tdata_s", td_s, 64'd0);
    check("midreset_tdata_u", td_u, 64'd0);
    check("midreset_ready", {63'd0, all_ready()}, 64'd1);
    watch_idle(50, seen);
    check("midreset_no_tvalid", 64'(seen), 64'd0);

    // Randomized operands against a behavioural / and % model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      int mode;
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (mode)
        1: begin
          a = 32'($signed($urandom_range(0, 100)) - 50);
          b = 32'($signed($urandom_range(0, 100)) - 50);
        end
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = 32'($urandom_range(1, 20));
        5: b[31] = 1'b1;
        default: begin end
      endcase
      run_op(a, b, rs, ru, lat_s, lat_u);
      check($sformatf("rnd%0d_s %h/%h", i, a, b), rs, model_s(a, b));
      check($sformatf("rnd%0d_u %h/%h", i, a, b), ru, model_u(a, b));
      check($sformatf("rnd%0d_lat", i), 64'(lat_s), 64'(LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
